data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/mem_pkg.sv | 32 +++
 rtl/data_mem_lane_align.sv | 47 ++++
 rtl/data_mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data memory controller: access widths, FSM states,
// the registered response bundle and the word-crossing classifier.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'b00,
    MEM_HALF    = 2'b01,
    MEM_WORD    = 2'b10,
    MEM_ILLEGAL = 2'b11
  } mem_width_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BEAT2 = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } mem_resp_t;

  // Bytes never cross; illegal widths are reported as errors, not splits.
  function automatic logic is_crossing(input mem_width_e width, input logic [1:0] offset);
    case (width)
      MEM_HALF: return offset == 2'd3;
      MEM_WORD: return offset != 2'd0;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_lane_align.sv
// Byte-lane steering across a two-word window: store byte enables and data
// for word W / W+1, and little-endian load merge with zero/sign extension.
module data_mem_lane_align
  import mem_pkg::*;
(
  input  mem_width_e  width,
  input  logic [1:0]  offset,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wd_lo,
  output logic [31:0] wd_hi,
  output logic [31:0] rdata
);

  logic [3:0]  size_mask;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [31:0] rd_sh;

  always_comb begin
    case (width)
      MEM_BYTE: size_mask = 4'b0001;
      MEM_HALF: size_mask = 4'b0011;
      MEM_WORD: size_mask = 4'b1111;
      default:  size_mask = 4'b0000;
    endcase
    be_wide = {4'b0000, size_mask} << offset;
    wd_wide = {32'b0, wdata} << {offset, 3'b000};
    rd_sh   = 32'({hi_word, lo_word} >> {offset, 3'b000});
    case (width)
      MEM_BYTE: rdata = uns ? {24'b0, rd_sh[7:0]}   : {{24{rd_sh[7]}}, rd_sh[7:0]};
      MEM_HALF: rdata = uns ? {16'b0, rd_sh[15:0]}  : {{16{rd_sh[15]}}, rd_sh[15:0]};
      MEM_WORD: rdata = rd_sh;
      default:  rdata = 32'b0;
    endcase
  end

  assign be_lo = be_wide[3:0];
  assign be_hi = be_wide[7:4];
  assign wd_lo = wd_wide[31:0];
  assign wd_hi = wd_wide[63:32];

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with one request per cycle; word-crossing
// accesses take a second beat on word W+1 (wrapping) or are rejected.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS      = 2048,
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter bit TRACE_EN         = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  typedef logic [AW-1:0] idx_t;

  logic [31:0] mem [DEPTH_WORDS];

  mem_state_e state, state_n;
  mem_resp_t  resp, resp_n;

  // Request held across the second beat
  logic        lat_write, lat_uns;
  mem_width_e  lat_width;
  logic [1:0]  lat_off;
  idx_t        lat_idx;
  logic [31:0] lat_wdata, lat_pc, lat_lo;

  mem_width_e  in_width;
  idx_t        in_idx, hi_idx, wr_idx;
  logic [1:0]  in_off;
  logic        in_cross, in_err, accept, latch, wr_en, in_beat2;
  logic [3:0]  be_lo, be_hi, wr_be;
  logic [31:0] wd_lo, wd_hi, wr_data, rdata, cur_pc;

  assign in_width = mem_width_e'(req_width);
  assign in_idx   = req_addr[AW+1:2];
  assign in_off   = req_addr[1:0];
  assign in_cross = is_crossing(in_width, in_off);
  assign in_err   = (in_width == MEM_ILLEGAL) || (in_cross && !ALLOW_MISALIGNED);
  assign in_beat2 = (state == BEAT2);
  assign req_ready = !in_beat2;
  assign accept   = req_valid && req_ready;
  assign hi_idx   = lat_idx + 1'b1;
  assign cur_pc   = in_beat2 ? lat_pc : pc;

  data_mem_lane_align u_align (
    .width   (in_beat2 ? lat_width : in_width),
    .offset  (in_beat2 ? lat_off   : in_off),
    .uns     (in_beat2 ? lat_uns   : req_unsigned),
    .wdata   (in_beat2 ? lat_wdata : req_wdata),
    .lo_word (in_beat2 ? lat_lo    : mem[in_idx]),
    .hi_word (mem[hi_idx]),
    .be_lo   (be_lo),
    .be_hi   (be_hi),
    .wd_lo   (wd_lo),
    .wd_hi   (wd_hi),
    .rdata   (rdata)
  );

  always_comb begin
    state_n = state;
    resp_n  = '0;
    latch   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = in_idx;
    wr_be   = be_lo;
    wr_data = wd_lo;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_err) begin
            resp_n.valid = 1'b1;
            resp_n.err   = 1'b1;
          end else begin
            wr_en = req_write;
            if (in_cross) begin
              latch   = 1'b1;
              state_n = BEAT2;
            end else begin
              resp_n.valid = 1'b1;
              resp_n.rdata = req_write ? 32'b0 : rdata;
            end
          end
        end
      end
      BEAT2: begin
        wr_en        = lat_write;
        wr_idx       = hi_idx;
        wr_be        = be_hi;
        wr_data      = wd_hi;
        resp_n.valid = 1'b1;
        resp_n.rdata = lat_write ? 32'b0 : rdata;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      resp  <= '0;
    end else begin
      state <= state_n;
      resp  <= resp_n;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      lat_write <= req_write;
      lat_uns   <= req_unsigned;
      lat_width <= in_width;
      lat_off   <= in_off;
      lat_idx   <= in_idx;
      lat_wdata <= req_wdata;
      lat_pc    <= pc;
      lat_lo    <= mem[in_idx];
    end
  end

  // Per-lane write enables; reset clears the whole array
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  assign resp_valid = resp.valid;
  assign resp_err   = resp.err;
  assign resp_rdata = resp.rdata;

  if (TRACE_EN) begin : g_trace
`ifndef SYNTHESIS
    logic [31:0] new_word;
    always_comb begin
      new_word = mem[wr_idx];
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) new_word[8*b +: 8] = wr_data[8*b +: 8];
    end
    always_ff @(posedge clk)
      if (!rst && wr_en) $display("@%h: *%h <= %h", cur_pc, 32'({wr_idx, 2'b00}), new_word);
`endif
  end

  logic unused_bits;
  assign unused_bits = ^{req_addr, cur_pc};

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench with a response scoreboard: u_a splits crossing accesses
// (16 words, exercises wrap/alias), u_b rejects them.
module tb_data_mem_ctrl;

  localparam logic [1:0] W_B = 2'b00, W_H = 2'b01, W_W = 2'b10, W_X = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_width;
  logic        valid_a, valid_b, ready_a, ready_b;
  logic        resp_valid_a, resp_valid_b, resp_err_a, resp_err_b;
  logic [31:0] resp_rdata_a, resp_rdata_b;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(16), .ALLOW_MISALIGNED(1'b1), .TRACE_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .pc(pc), .req_valid(valid_a), .req_ready(ready_a),
    .req_write(req_write), .req_addr(req_addr), .req_width(req_width),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
  );

  data_mem_ctrl #(.DEPTH_WORDS(64), .ALLOW_MISALIGNED(1'b0), .TRACE_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .pc(pc), .req_valid(valid_b), .req_ready(ready_b),
    .req_write(req_write), .req_addr(req_addr), .req_width(req_width),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q_a[$], q_b[$];
  exp_t ea, eb;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (resp_valid_a === 1'b1) begin
      chk("a_resp_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        ea = q_a.pop_front();
        chk("a_rdata", resp_rdata_a, ea.rdata);
        chk("a_err", 32'(resp_err_a), 32'(ea.err));
        chk("a_cycle", cyc, ea.due);
      end
    end
    if (resp_valid_b === 1'b1) begin
      chk("b_resp_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        eb = q_b.pop_front();
        chk("b_rdata", resp_rdata_b, eb.rdata);
        chk("b_err", 32'(resp_err_b), 32'(eb.err));
        chk("b_cycle", cyc, eb.due);
      end
    end
  end

  // Holds the request until the selected DUT is ready, then queues the expectation
  task automatic issue(input bit sel_b, input bit wr, input logic [31:0] addr,
                       input logic [1:0] w, input bit uns, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input bit exp_err, input int lat,
                       input bit push = 1'b1);
    int   tries = 0;
    exp_t e;
    pc           = pc + 32'd4;
    req_write    = wr;
    req_addr     = addr;
    req_width    = w;
    req_unsigned = uns;
    req_wdata    = wd;
    if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
    while ((sel_b ? ready_b : ready_a) !== 1'b1 && tries < 8) begin
      @(posedge clk); #1;
      tries++;
    end
    if (tries >= 8) begin
      chk("ready_timeout", 32'(sel_b ? ready_b : ready_a), 32'd1);
      valid_a = 1'b0;
      valid_b = 1'b0;
    end else begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.due   = cyc + lat;
      if (push) begin
        if (sel_b) q_b.push_back(e); else q_a.push_back(e);
      end
      @(posedge clk); #1;
      valid_a = 1'b0;
      valid_b = 1'b0;
      if (lat == 2) chk(sel_b ? "b_ready_beat2" : "a_ready_beat2", 32'(sel_b ? ready_b : ready_a), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pc = 32'h1000; valid_a = 1'b0; valid_b = 1'b0;
    req_write = 1'b0; req_addr = '0; req_width = W_W; req_unsigned = 1'b0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid_a), 32'd0);
    chk("rst_resp_rdata", resp_rdata_a, 32'd0);
    chk("rst_resp_err", 32'(resp_err_a), 32'd0);
    rst = 1'b0;
    chk("rst_ready_a", 32'(ready_a), 32'd1);
    chk("rst_ready_b", 32'(ready_b), 32'd1);

    // aligned word store/load
    issue(0, 1, 32'h10, W_W, 0, 32'h11223344, 32'h0, 0, 1);
    issue(0, 0, 32'h10, W_W, 0, 32'h0, 32'h11223344, 0, 1);
    // crossing word at offset 1: bytes 0D..0F in word 0x0C, byte 10 in word 0x10
    issue(0, 1, 32'h0D, W_W, 0, 32'hAABBCCDD, 32'h0, 0, 2);
    issue(0, 0, 32'h0D, W_W, 0, 32'h0, 32'hAABBCCDD, 0, 2);
    issue(0, 0, 32'h0C, W_W, 0, 32'h0, 32'hBBCCDD00, 0, 1);
    issue(0, 0, 32'h10, W_W, 0, 32'h0, 32'h112233AA, 0, 1);
    // byte store and sign/zero-extended loads
    issue(0, 1, 32'h20, W_W, 0, 32'hCAFEF00D, 32'h0, 0, 1);
    issue(0, 1, 32'h21, W_B, 0, 32'h00000080, 32'h0, 0, 1);
    issue(0, 0, 32'h21, W_B, 0, 32'h0, 32'hFFFFFF80, 0, 1);
    issue(0, 0, 32'h21, W_B, 1, 32'h0, 32'h00000080, 0, 1);
    issue(0, 0, 32'h20, W_W, 0, 32'h0, 32'hCAFE800D, 0, 1);
    issue(0, 0, 32'h22, W_H, 0, 32'h0, 32'hFFFFCAFE, 0, 1);
    issue(0, 0, 32'h22, W_H, 1, 32'h0, 32'h0000CAFE, 0, 1);
    issue(0, 0, 32'h23, W_W, 0, 32'h0, 32'h000000CA, 0, 2);
    // halfword wrapping from the last word to word 0, plus aliasing
    issue(0, 1, 32'h3F, W_H, 0, 32'h0000BEEF, 32'h0, 0, 2);
    issue(0, 0, 32'h3F, W_H, 1, 32'h0, 32'h0000BEEF, 0, 2);
    issue(0, 0, 32'h3F, W_H, 0, 32'h0, 32'hFFFFBEEF, 0, 2);
    issue(0, 0, 32'h3C, W_W, 0, 32'h0, 32'hEF000000, 0, 1);
    issue(0, 0, 32'h00, W_W, 0, 32'h0, 32'h000000BE, 0, 1);
    issue(0, 0, 32'h40, W_W, 0, 32'h0, 32'h000000BE, 0, 1);
    // illegal width: error, no write
    issue(0, 1, 32'h20, W_X, 0, 32'hFFFFFFFF, 32'h0, 1, 1);
    issue(0, 0, 32'h20, W_X, 0, 32'h0, 32'h0, 1, 1);
    issue(0, 0, 32'h20, W_W, 0, 32'h0, 32'hCAFE800D, 0, 1);
    // store then load of the same byte on consecutive cycles
    issue(0, 1, 32'h31, W_B, 0, 32'h0000005A, 32'h0, 0, 1);
    issue(0, 0, 32'h31, W_B, 1, 32'h0, 32'h0000005A, 0, 1);

    // misaligned accesses rejected
    issue(1, 1, 32'h00, W_W, 0, 32'h12345678, 32'h0, 0, 1);
    issue(1, 0, 32'h02, W_W, 0, 32'h0, 32'h0, 1, 1);
    issue(1, 1, 32'h02, W_W, 0, 32'hFFFFFFFF, 32'h0, 1, 1);
    issue(1, 0, 32'h03, W_H, 0, 32'h0, 32'h0, 1, 1);
    issue(1, 0, 32'h00, W_W, 0, 32'h0, 32'h12345678, 0, 1);
    issue(1, 0, 32'h02, W_H, 0, 32'h0, 32'h00001234, 0, 1);

    // reset during the second beat drops the response and clears memory
    issue(0, 1, 32'h06, W_W, 0, 32'hFFFFFFFF, 32'h0, 0, 2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_beat2_no_resp", 32'(resp_valid_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_beat2_ready", 32'(ready_a), 32'd1);
    issue(0, 0, 32'h04, W_W, 0, 32'h0, 32'h0, 0, 1);
    issue(0, 0, 32'h08, W_W, 0, 32'h0, 32'h0, 0, 1);
    issue(0, 0, 32'h10, W_W, 0, 32'h0, 32'h0, 0, 1);
    issue(0, 0, 32'h3C, W_W, 0, 32'h0, 32'h0, 0, 1);

    repeat (4) @(posedge clk);
    #1;
    chk("a_pending_left", 32'(q_a.size()), 32'd0);
    chk("b_pending_left", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
